// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for the two register-file producers, with a
// registered write port and a combinational bypass from that write register.
module regfile_wb_arbiter #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          v0,
    input  logic [AW-1:0] a0,
    input  logic [DW-1:0] d0,
    output logic          r0,
    input  logic          v1,
    input  logic [AW-1:0] a1,
    input  logic [DW-1:0] d1,
    output logic          r1,
    input  logic          hold,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    output logic          fwd1,
    output logic          fwd2,
    output logic [DW-1:0] fdata1,
    output logic [DW-1:0] fdata2
);

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    port_e         last_q, last_d;
    logic          we_q, we_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          gnt0, gnt1;

    // rst is folded in so readies drop the moment reset asserts, not at the next edge.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst && !hold) begin
            gnt0 = v0 && (!v1 || last_q == PORT1);
            gnt1 = v1 && (!v0 || last_q == PORT0);
        end
    end

    always_comb begin
        last_d  = last_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (gnt0) begin
            last_d  = PORT0;
            we_d    = (a0 != '0);
            waddr_d = a0;
            wdata_d = d0;
        end else if (gnt1) begin
            last_d  = PORT1;
            we_d    = (a1 != '0);
            waddr_d = a1;
            wdata_d = d1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q  <= PORT1;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            last_q  <= last_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign r0     = gnt0;
    assign r1     = gnt1;
    assign we     = we_q;
    assign waddr  = waddr_q;
    assign wdata  = wdata_q;
    assign fwd1   = we_q && (raddr1 == waddr_q) && (raddr1 != '0);
    assign fwd2   = we_q && (raddr2 == waddr_q) && (raddr2 != '0);
    assign fdata1 = fwd1 ? wdata_q : '0;
    assign fdata2 = fwd2 ? wdata_q : '0;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a
// transaction-level model of pending requests and fair grant order.
module tb_regfile_wb_arbiter;
    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          v0, v1, hold;
    logic [AW-1:0] a0, a1, raddr1, raddr2;
    logic [DW-1:0] d0, d1;
    logic          r0, r1, we, fwd1, fwd2;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata, fdata1, fdata2;

    regfile_wb_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .v0(v0), .a0(a0), .d0(d0), .r0(r0),
        .v1(v1), .a1(a1), .d1(d1), .r1(r1),
        .hold(hold),
        .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2),
        .fwd1(fwd1), .fwd2(fwd2), .fdata1(fdata1), .fdata2(fdata2)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: outstanding request per port, who was served most recently,
    // and what the write register should be showing.
    logic          p_v [2];
    logic [AW-1:0] p_a [2];
    logic [DW-1:0] p_d [2];
    logic          h_m;
    int            served_last;
    logic          e_we;
    logic [AW-1:0] e_waddr;
    logic [DW-1:0] e_wdata;
    bit            gen_en;
    int            winner;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_bypass();
        logic          ex1, ex2;
        ex1 = e_we && (raddr1 == e_waddr) && (raddr1 != 0);
        ex2 = e_we && (raddr2 == e_waddr) && (raddr2 != 0);
        check("fwd1", fwd1, ex1);
        check("fwd2", fwd2, ex2);
        check("fdata1", fdata1, ex1 ? e_wdata : 0);
        check("fdata2", fdata2, ex2 ? e_wdata : 0);
    endtask

    task automatic gen_request(input int p);
        p_v[p] = ($urandom_range(0, 99) < 60);
        p_a[p] = AW'($urandom_range(0, 7));
        p_d[p] = $urandom;
    endtask

    // One clock cycle: drive, check readies, take the edge, check the write port.
    task automatic step();
        v0 = p_v[0]; a0 = p_a[0]; d0 = p_d[0];
        v1 = p_v[1]; a1 = p_a[1]; d1 = p_d[1];
        hold = h_m;
        #1;
        winner = -1;
        if (!h_m) begin
            if (p_v[0] && p_v[1]) winner = (served_last == 0) ? 1 : 0;
            else if (p_v[0])      winner = 0;
            else if (p_v[1])      winner = 1;
        end
        check("r0", r0, winner == 0);
        check("r1", r1, winner == 1);
        @(posedge clk);
        if (winner >= 0) begin
            e_we        = (p_a[winner] != 0);
            e_waddr     = p_a[winner];
            e_wdata     = p_d[winner];
            served_last = winner;
            p_v[winner] = 1'b0;
        end else begin
            e_we = 1'b0;
        end
        #1;
        check("we", we, e_we);
        check("waddr", waddr, e_waddr);
        check("wdata", wdata, e_wdata);
        raddr1 = ($urandom_range(0, 3) == 0) ? e_waddr : AW'($urandom_range(0, 7));
        raddr2 = ($urandom_range(0, 3) == 0) ? e_waddr : AW'($urandom_range(0, 7));
        #1;
        check_bypass();
        if (gen_en) begin
            for (int p = 0; p < 2; p++) if (!p_v[p]) gen_request(p);
            h_m = ($urandom_range(0, 99) < 15);
        end
    endtask

    task automatic model_reset();
        e_we = 1'b0; e_waddr = '0; e_wdata = '0; served_last = 1;
    endtask

    initial begin
        logic [AW-1:0] seq_exp [4];
        seq_exp[0] = 5'd3; seq_exp[1] = 5'd4; seq_exp[2] = 5'd3; seq_exp[3] = 5'd4;
        gen_en = 1'b0; h_m = 1'b0;
        for (int p = 0; p < 2; p++) begin p_v[p] = 1'b0; p_a[p] = '0; p_d[p] = '0; end
        v0 = 0; v1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0; hold = 0;
        raddr1 = 0; raddr2 = 0;
        model_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_we", we, 0);
        check("rst_waddr", waddr, 0);
        check("rst_wdata", wdata, 0);
        @(negedge clk) rst = 1'b0;

        // Contention right after reset: port 0 first, then alternation.
        for (int i = 0; i < 4; i++) begin
            if (!p_v[0]) begin p_v[0] = 1; p_a[0] = 5'd3; p_d[0] = $urandom; end
            if (!p_v[1]) begin p_v[1] = 1; p_a[1] = 5'd4; p_d[1] = $urandom; end
            step();
            check("contention_seq", waddr, seq_exp[i]);
        end
        p_v[0] = 0; p_v[1] = 0;
        step();

        // Single port write, then idle.
        p_v[0] = 1; p_a[0] = 5'd5; p_d[0] = 32'hDEADBEEF;
        step();
        check("single_waddr", waddr, 5);
        check("single_wdata", wdata, 32'hDEADBEEF);
        step();
        check("single_idle_we", we, 0);

        // Register 0 is consumed but never written.
        p_v[1] = 1; p_a[1] = '0; p_d[1] = 32'h12345678;
        step();
        raddr1 = '0; #1;
        check("reg0_we", we, 0);
        check("reg0_fwd1", fwd1, 0);

        // Bypass hit on one read port, miss on the other.
        p_v[0] = 1; p_a[0] = 5'd7; p_d[0] = 32'hA5A5A5A5;
        step();
        raddr1 = 5'd7; raddr2 = 5'd8; #1;
        check("byp_fwd1", fwd1, 1);
        check("byp_fdata1", fdata1, 32'hA5A5A5A5);
        check("byp_fwd2", fwd2, 0);
        check("byp_fdata2", fdata2, 0);

        // Hold with both ports waiting, then release.
        p_v[0] = 1; p_a[0] = 5'd9;  p_d[0] = 32'h11111111;
        p_v[1] = 1; p_a[1] = 5'd10; p_d[1] = 32'h22222222;
        h_m = 1;
        repeat (3) step();
        h_m = 0;
        step();
        check("hold_release_first", waddr, 10);
        step();
        check("hold_release_second", waddr, 9);

        gen_en = 1'b1;
        repeat (300) step();

        // Reset asserted mid-cycle with a live request.
        gen_en = 1'b0; h_m = 0;
        p_v[0] = 1; p_a[0] = 5'd6; p_d[0] = 32'hCAFEF00D; p_v[1] = 0;
        v0 = 1; a0 = 5'd6; d0 = 32'hCAFEF00D; v1 = 0; hold = 0;
        @(posedge clk); #3;
        rst = 1'b1; raddr1 = 5'd6; #1;
        check("mid_rst_we", we, 0);
        check("mid_rst_waddr", waddr, 0);
        check("mid_rst_wdata", wdata, 0);
        check("mid_rst_r0", r0, 0);
        check("mid_rst_fwd1", fwd1, 0);
        model_reset();
        @(negedge clk) rst = 1'b0;
        p_v[0] = 1; p_a[0] = 5'd12; p_d[0] = $urandom;
        p_v[1] = 1; p_a[1] = 5'd13; p_d[1] = $urandom;
        step();
        check("post_rst_first_grant", waddr, 12);

        gen_en = 1'b1;
        repeat (300) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
